// File: rtl/uart_tx.sv
// UART transmitter: accepts one word over a valid/ready handshake and shifts it out on TxD as
// start bit, data bits LSB first, optional parity bit and one or two stop bits.
// All outputs, including TxD, come straight from flops so the line never glitches.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  TxD,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned IdxW       = $clog2(DATA_WIDTH) + 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_WIDTH - 1);
  localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);

  // Reject configurations the bit timing cannot represent.
  if (ClksPerBit < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;       // clocks elapsed within the current bit
  logic [IdxW-1:0]         idx_q, idx_d;       // data bit index, reused for stop bits
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;   // remaining data, next bit in [0]
  logic                    parity_q, parity_d;
  logic                    txd_q, txd_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end;

  assign bit_end  = (cnt_q == CntLast);

  assign TxD      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  // Next-state and next-output logic; outputs are computed one cycle ahead so they register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    txd_d    = txd_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        // ready_q is always high in this state, so tx_valid alone completes the handshake.
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ (PARITY_ODD != 0);
          state_d  = StStart;
          txd_d    = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end

      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StData;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == DataLast) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = StParity;
              txd_d   = parity_q;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
            txd_d   = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StStop;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == StopLast) begin
            // Back in idle next cycle; that cycle carries the done pulse and can accept again.
            idx_d   = '0;
            state_d = StIdle;
            txd_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset mid-frame returns the line to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (even parity / odd parity / no parity + 2 stop bits).
// A driver per configuration pushes the expected frame into a queue at each accept; a monitor
// detects start bits on TxD, pops the queue and checks every bit mid-cell plus done timing.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [11:0] bits;  // frame bits in line order, [0] = start bit
    int          acc;   // cycle of the first start-bit cycle
  } item_t;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int C  = (g == 0) ? 8 : (g == 1) ? 6 : 5;
    localparam int PE = (g == 2) ? 0 : 1;
    localparam int PO = (g == 1) ? 1 : 0;
    localparam int SB = (g == 2) ? 2 : 1;
    localparam int NB = 1 + 8 + PE + SB;
    localparam int L  = NB * C;

    logic       reset    = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = '0;
    logic       tx_ready, txd, tx_busy, tx_done;

    item_t q[$];
    int    ready_at = 0;
    int    rst_cnt  = 0;
    int    n_done   = 0;
    int    exp_done = 0;
    bit    fin      = 1'b0;

    uart_tx #(
      .CLK_FREQ  (C * 1000),
      .BAUD_RATE (1000),
      .DATA_WIDTH(8),
      .PARITY_EN (PE),
      .PARITY_ODD(PO),
      .STOP_BITS (SB)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .TxD     (txd),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
    );

    always @(posedge clk) if (reset) rst_cnt <= rst_cnt + 1;
    always @(negedge clk) if (tx_done) n_done <= n_done + 1;

    // Reference frame: start 0, data LSB first, parity from the count of ones, then stop 1s.
    function automatic logic [11:0] frame_bits(input logic [7:0] d);
      logic [11:0] b;
      int ones;
      b    = '1;
      ones = 0;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        b[1 + i] = d[i];
        if (d[i]) ones++;
      end
      if (PE != 0) b[9] = ((ones % 2) == 1) != (PO == 1);
      return b;
    endfunction

    task automatic do_reset();
      reset    = 1'b1;
      tx_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("cfg%0d reset txd_ready", g), {txd, tx_ready}, 2'b11);
      chk($sformatf("cfg%0d reset busy_done", g), {tx_busy, tx_done}, 2'b00);
      reset    = 1'b0;
      ready_at = cyc;
    endtask

    // Called at a negedge; returns at the negedge where the frame's start bit is on the line.
    task automatic send(input logic [7:0] d, input bit hold, output int acc);
      while (cyc < ready_at) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      acc = cyc;
      q.push_back('{bits: frame_bits(d), acc: acc});
      ready_at = acc + L;
      exp_done++;
      tx_data = 8'($urandom);
      if (!hold) tx_valid = 1'b0;
    endtask

    initial begin : drive
      int acc;
      bit hold, prev_hold;
      do_reset();
      send(8'hA5, 1'b0, acc);
      send(8'h00, 1'b0, acc);
      send(8'hFF, 1'b0, acc);
      send(8'h3C, 1'b0, acc);
      // Back-to-back with tx_valid held, then a stray pulse mid-frame that must be dropped.
      send(8'h55, 1'b1, acc);
      send(8'hAA, 1'b0, acc);
      while (cyc < acc + L / 2) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h12;
      @(negedge clk);
      tx_valid = 1'b0;
      // Abort 0xF0 during data bit 3 (frame bit 4), then send 0x81 cleanly.
      send(8'hF0, 1'b0, acc);
      exp_done--;
      while (cyc < acc + 4 * C + 1) @(negedge clk);
      do_reset();
      send(8'h81, 1'b0, acc);
      prev_hold = 1'b0;
      for (int i = 0; i < 24; i++) begin
        if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        hold = (i < 23) && ($urandom_range(0, 1) == 1);
        send(8'($urandom), hold, acc);
        prev_hold = hold;
      end
      while (cyc < ready_at + 2) @(negedge clk);
      chk($sformatf("cfg%0d done_count", g), n_done, exp_done);
      chk($sformatf("cfg%0d queue_left", g), q.size(), 0);
      fin = 1'b1;
    end

    initial begin : monitor
      item_t it;
      int    rc, t;
      bit    ab;
      forever begin
        @(negedge clk);
        if (reset || txd !== 1'b0) continue;
        chk($sformatf("cfg%0d frame_expected", g), q.size() != 0, 1'b1);
        if (q.size() == 0) begin
          repeat (L) @(negedge clk);
          continue;
        end
        it = q.pop_front();
        rc = rst_cnt;
        ab = 1'b0;
        chk($sformatf("cfg%0d start_cycle", g), cyc, it.acc);
        for (int i = 0; i < NB && !ab; i++) begin
          t = it.acc + i * C + C / 2;
          while (!ab && cyc < t) begin
            @(negedge clk);
            if (rst_cnt != rc) ab = 1'b1;
          end
          if (!ab) begin
            chk($sformatf("cfg%0d bit%0d", g, i), txd, it.bits[i]);
            chk($sformatf("cfg%0d ready_busy_in_frame", g), {tx_ready, tx_busy}, 2'b01);
          end
        end
        t = it.acc + L;
        while (!ab && cyc < t) begin
          @(negedge clk);
          if (rst_cnt != rc) ab = 1'b1;
        end
        if (!ab) begin
          chk($sformatf("cfg%0d done_ready_busy", g), {tx_done, tx_ready, tx_busy}, 3'b110);
        end
      end
    end
  end

  initial begin : main
    bit all_fin;
    all_fin = 1'b0;
    for (int i = 0; i < 60000 && !all_fin; i++) begin
      @(negedge clk);
      all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
    end
    chk("all_configs_finished", all_fin, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
